uart_frame_scheduler: RTL and testbench
=======================================

Name: uart_frame_scheduler

Overview:
Sequences the UART transmit datapath for the two-player link. It periodically, or on demand, snapshots a game-state payload and frames it as SYNC, SEQ, payload bytes and CHECKSUM. It feeds the frame byte by byte to the byte transmitter using a tx_start/tx_done_tick handshake. It sits between the game-state logic and uart_tx, in the same clock domain as the baud generator (65 MHz).

Parameters:
PAYLOAD_BYTES, 7, number of payload bytes per frame (1..32)
PERIOD_CYCLES, 1083333, clocks between periodic frame triggers (about 60 Hz at 65 MHz)
TIMEOUT_CYCLES, 32768, max clocks to wait for tx_done_tick per byte
SYNC_BYTE, 8'hA5, first byte of every frame

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
enable  in  1  1 = scheduler active
send_now  in  1  one-cycle request for an immediate frame
payload_in  in  8*PAYLOAD_BYTES  game-state payload; byte k = payload_in[8k+7:8k]
tx_done_tick  in  1  one-cycle pulse from uart_tx when a byte has finished
tx_start  out  1  one-cycle pulse to uart_tx
tx_data  out  8  byte to transmit; valid with tx_start and held until the next tx_start
busy  out  1  frame in progress
frame_done  out  1  one-cycle pulse after the checksum byte completes
tx_error  out  1  one-cycle pulse when a frame is aborted by timeout
seq_out  out  8  sequence number of the next frame

Behaviour:
- Reset (asynchronous, any state): state=IDLE; tx_start=0, tx_data=0, busy=0, frame_done=0, tx_error=0, seq=0, timer=0, pending=0, idx=0, checksum accumulator=0, snapshot=0.
- Frame layout, with L = PAYLOAD_BYTES+3 bytes:
  - idx 0: SYNC_BYTE
  - idx 1: seq
  - idx 2..L-2: payload byte idx-2 from the snapshot, LSB byte first
  - idx L-1: checksum = XOR of the seq byte and all payload bytes (SYNC excluded)
- Period timer:
  - enable=1: counts 0..PERIOD_CYCLES-1 and wraps; the wrap cycle sets pending.
  - enable=0: timer held at 0.
- send_now while enable=1 sets pending.
- Triggers coalesce: pending is a single flag.
- A trigger arriving during a frame leaves pending set, so the next frame starts right after the current one completes.
- enable=0: pending cleared and send_now ignored. A frame already in progress still runs to completion.
- FSM states are IDLE, SEND, WAIT.
  - IDLE: when enable & pending:
    - capture payload_in into the snapshot and clear pending;
    - idx=0, accumulator=0, busy=1;
    - next state SEND.
    - If a trigger occurs in the same cycle pending is cleared, pending stays set instead.
  - SEND (exactly one cycle):
    - tx_start=1 and tx_data=byte(idx) in this same cycle;
    - if idx>=1, accumulator ^= byte(idx) (the checksum byte itself excluded);
    - timeout counter cleared;
    - next state WAIT.
  - WAIT: tx_start=0, tx_data held. Checks in priority order:
    - tx_done_tick and idx<L-1: idx++, go to SEND.
    - tx_done_tick and idx==L-1: frame_done pulse, seq=seq+1 mod 256, busy=0, go to IDLE.
    - Otherwise, if the counter reaches TIMEOUT_CYCLES-1: tx_error pulse, busy=0, go to IDLE. seq is not incremented and pending is unchanged.
- tx_done_tick outside WAIT is ignored.
- Latency: trigger at cycle t while IDLE means pending=1 at t+1, capture at t+1, tx_start at t+2.
- Back-to-back frames: the cycle after frame_done is IDLE; if pending is set, the next tx_start follows 2 cycles later.
- seq_out always reflects the seq register.
- The snapshot is stable for the whole frame; payload_in changes mid-frame have no effect.

Test Plan:
Use PAYLOAD_BYTES=2, PERIOD_CYCLES=100, TIMEOUT_CYCLES=50. The bench uart_tx model returns tx_done_tick 10 cycles after each tx_start.
1. Reset, enable=1, payload_in=16'h3412, no send_now -> first frame begins 2 cycles after timer wrap at cycle 100; bytes A5,00,12,34,26; frame_done once; seq_out becomes 01.
2. send_now pulse at cycle 5 with payload 16'hFF00 -> tx_start at cycle 7; bytes A5,00,00,FF,FF; a second send_now mid-frame produces exactly one following frame with seq 01.
3. payload_in changed during WAIT of byte idx 2 -> transmitted bytes and checksum match the snapshot taken at frame start.
4. Model withholds tx_done_tick after SEQ byte -> tx_error pulse 50 cycles after that tx_start; busy=0; seq_out unchanged (00); next trigger restarts from SYNC.
5. Assert reset during WAIT of payload byte -> all outputs return to reset values immediately; after release no tx_start until a new trigger.
6. enable=0 mid-frame with pending set -> frame completes with frame_done; pending cleared; no further frames; timer stays at 0.

Source files
------------

// File: rtl/uart_frame_scheduler.sv
// Frames a game-state snapshot as SYNC, SEQ, payload, CHECKSUM and feeds it byte by
// byte to uart_tx over a tx_start / tx_done_tick handshake, periodically or on demand.
module uart_frame_scheduler #(
    parameter int          PAYLOAD_BYTES  = 7,
    parameter int          PERIOD_CYCLES  = 1083333,
    parameter int          TIMEOUT_CYCLES = 32768,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    input  logic                       send_now,
    input  logic [8*PAYLOAD_BYTES-1:0] payload_in,
    input  logic                       tx_done_tick,
    output logic                       tx_start,
    output logic [7:0]                 tx_data,
    output logic                       busy,
    output logic                       frame_done,
    output logic                       tx_error,
    output logic [7:0]                 seq_out
);
    localparam int L  = PAYLOAD_BYTES + 3;
    localparam int IW = $clog2(L);
    localparam int PW = $clog2(PERIOD_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IW-1:0] LAST = IW'(L - 1);
    localparam logic [PW-1:0] PMAX = PW'(PERIOD_CYCLES - 1);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SEND, WAIT} state_t;

    state_t                     state, state_nx;
    logic [PW-1:0]              timer;
    logic [TW-1:0]              tmo;
    logic [IW-1:0]              idx;
    logic [7:0]                 seq, acc, data_q, cur_byte;
    logic [8*PAYLOAD_BYTES-1:0] snap;
    logic                       pending, timer_wrap, trigger, capture;

    assign timer_wrap = enable && (timer == PMAX);
    assign trigger    = enable && (timer_wrap || send_now);
    assign capture    = (state == IDLE) && enable && pending;

    assign busy    = (state != IDLE);
    assign seq_out = seq;
    // tx_data is driven straight from the byte mux during SEND so it is valid with tx_start.
    assign tx_data = (state == SEND) ? cur_byte : data_q;

    always_comb begin
        cur_byte = snap[7:0];
        if (idx == '0)
            cur_byte = SYNC_BYTE;
        else if (idx == IW'(1))
            cur_byte = seq;
        else if (idx == LAST)
            cur_byte = acc;
        else
            for (int k = 0; k < PAYLOAD_BYTES; k++)
                if (idx == IW'(k + 2)) cur_byte = snap[8*k +: 8];
    end

    always_comb begin
        state_nx   = state;
        tx_start   = 1'b0;
        frame_done = 1'b0;
        tx_error   = 1'b0;
        case (state)
            IDLE: if (capture) state_nx = SEND;
            SEND: begin
                tx_start = 1'b1;
                state_nx = WAIT;
            end
            WAIT: begin
                if (tx_done_tick) begin
                    if (idx == LAST) begin
                        frame_done = 1'b1;
                        state_nx   = IDLE;
                    end else begin
                        state_nx = SEND;
                    end
                end else if (tmo == TMAX) begin
                    tx_error = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            timer   <= '0;
            tmo     <= '0;
            idx     <= '0;
            seq     <= '0;
            acc     <= '0;
            data_q  <= '0;
            snap    <= '0;
            pending <= 1'b0;
        end else begin
            state <= state_nx;
            timer <= (!enable || timer_wrap) ? '0 : timer + PW'(1);

            // A trigger landing on the capture cycle keeps pending set for the next frame.
            if (!enable)      pending <= 1'b0;
            else if (capture) pending <= trigger;
            else              pending <= pending || trigger;

            if (frame_done) seq <= seq + 8'd1;

            case (state)
                IDLE: if (capture) begin
                    snap <= payload_in;
                    idx  <= '0;
                    acc  <= '0;
                end
                SEND: begin
                    data_q <= cur_byte;
                    tmo    <= '0;
                    if (idx != '0 && idx != LAST) acc <= acc ^ cur_byte;
                end
                WAIT: begin
                    if (tx_done_tick) begin
                        if (idx != LAST) idx <= idx + IW'(1);
                    end else begin
                        tmo <= tmo + TW'(1);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_frame_scheduler.sv
// Directed bench for uart_frame_scheduler with a uart_tx stand-in that answers each
// tx_start with tx_done_tick 10 cycles later (or withholds it on request).
module tb_uart_frame_scheduler;
    localparam int PB = 2, PER = 100, TMO = 50;

    logic        clk = 1'b0, reset = 1'b1, enable = 1'b0, send_now = 1'b0, tx_done_tick = 1'b0;
    logic [15:0] payload_in = '0;
    logic        tx_start, busy, frame_done, tx_error;
    logic [7:0]  tx_data, seq_out;

    uart_frame_scheduler #(.PAYLOAD_BYTES(PB), .PERIOD_CYCLES(PER), .TIMEOUT_CYCLES(TMO),
                           .SYNC_BYTE(8'hA5)) dut (
        .clk(clk), .reset(reset), .enable(enable), .send_now(send_now),
        .payload_in(payload_in), .tx_done_tick(tx_done_tick), .tx_start(tx_start),
        .tx_data(tx_data), .busy(busy), .frame_done(frame_done), .tx_error(tx_error),
        .seq_out(seq_out));

    always #5 clk = ~clk;

    int checks = 0, errors = 0, cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // uart_tx stand-in
    int   mcnt = 0, tx_cnt = 0, drop_at = -1;
    logic withheld = 1'b0;
    always @(posedge clk) begin
        #1;
        tx_done_tick = 1'b0;
        if (mcnt != 0) begin
            mcnt--;
            if (mcnt == 0 && !withheld) tx_done_tick = 1'b1;
        end
        if (tx_start) begin
            withheld = (tx_cnt == drop_at);
            tx_cnt++;
            mcnt = 10;
        end
    end

    // monitor
    logic [7:0] bytes[$];
    int         start_cyc[$];
    int         n_done = 0, n_err = 0, done_cyc = 0, err_cyc = 0;
    always @(negedge clk) begin
        if (tx_start) begin
            bytes.push_back(tx_data);
            start_cyc.push_back(cyc);
        end
        if (frame_done) begin n_done++; done_cyc = cyc; end
        if (tx_error)   begin n_err++;  err_cyc  = cyc; end
    end

    typedef struct {
        logic [15:0] payload;
        logic [39:0] frame;
        logic [7:0]  seq_after;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_frame(input string name, input int base, input logic [39:0] e);
        logic [7:0] b;
        for (int i = 0; i < 5; i++) begin
            b = (base + i < bytes.size()) ? bytes[base + i] : 8'hxx;
            chk($sformatf("%s byte%0d", name, i), {24'h0, b}, {24'h0, e[39 - 8*i -: 8]});
        end
    endtask

    task automatic chk_reset_outputs(input string name);
        chk({name, " tx_start"},   {31'h0, tx_start},   32'h0);
        chk({name, " tx_data"},    {24'h0, tx_data},    32'h0);
        chk({name, " busy"},       {31'h0, busy},       32'h0);
        chk({name, " frame_done"}, {31'h0, frame_done}, 32'h0);
        chk({name, " tx_error"},   {31'h0, tx_error},   32'h0);
        chk({name, " seq_out"},    {24'h0, seq_out},    32'h0);
    endtask

    task automatic apply_reset(input string name);
        @(negedge clk);
        reset = 1'b1; enable = 1'b0; send_now = 1'b0;
        #1;
        chk_reset_outputs(name);
        repeat (3) @(negedge clk);
        bytes.delete(); start_cyc.delete();
        n_done = 0; n_err = 0; tx_cnt = 0; drop_at = -1;
    endtask

    task automatic pulse_send();
        send_now = 1'b1;
        @(negedge clk);
        send_now = 1'b0;
    endtask

    task automatic wait_end(input int n, input int budget, input string name);
        int k = 0;
        while (n_done + n_err < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk({name, " completion"}, {31'h0, (n_done + n_err >= n)}, 32'h1);
    endtask

    vec_t vecs[6];
    int   c0, d1, nb;

    initial begin
        vecs[0] = '{16'h3412, 40'hA5_00_12_34_26, 8'h01};
        vecs[1] = '{16'hFF00, 40'hA5_01_00_FF_FE, 8'h02};
        vecs[2] = '{16'h0000, 40'hA5_02_00_00_02, 8'h03};
        vecs[3] = '{16'hA5A5, 40'hA5_03_A5_A5_03, 8'h04};
        vecs[4] = '{16'h8001, 40'hA5_04_01_80_85, 8'h05};
        vecs[5] = '{16'h5AC3, 40'hA5_05_C3_5A_9C, 8'h06};

        // periodic trigger from reset
        apply_reset("t1 reset");
        reset = 1'b0; enable = 1'b1; payload_in = 16'h3412; c0 = cyc;
        wait_end(1, 250, "t1");
        chk("t1 start cycle", start_cyc.size() > 0 ? start_cyc[0] : -1, c0 + 101);
        chk_frame("t1", 0, 40'hA5_00_12_34_26);
        chk("t1 done cycle", done_cyc, (start_cyc.size() > 0 ? start_cyc[0] : 0) + 54);
        chk("t1 frame_done count", n_done, 1);
        chk("t1 seq_out", {24'h0, seq_out}, 32'h01);
        @(negedge clk);
        chk("t1 busy idle", {31'h0, busy}, 32'h0);
        enable = 1'b0;

        // send_now latency and coalesced mid-frame triggers
        apply_reset("t2 reset");
        reset = 1'b0; enable = 1'b1; payload_in = 16'hFF00; c0 = cyc;
        repeat (5) @(negedge clk);
        pulse_send();
        repeat (14) @(negedge clk);
        chk("t2 busy mid-frame", {31'h0, busy}, 32'h1);
        pulse_send();
        repeat (3) @(negedge clk);
        pulse_send();
        wait_end(1, 200, "t2 frame0");
        d1 = done_cyc;
        chk("t2 start cycle", start_cyc.size() > 0 ? start_cyc[0] : -1, c0 + 7);
        chk_frame("t2 frame0", 0, 40'hA5_00_00_FF_FF);
        repeat (10) @(negedge clk);
        enable = 1'b0;
        wait_end(2, 200, "t2 frame1");
        chk("t2 back-to-back start", start_cyc.size() > 5 ? start_cyc[5] : -1, d1 + 2);
        chk_frame("t2 frame1", 5, 40'hA5_01_00_FF_FE);
        repeat (150) @(negedge clk);
        chk("t2 no extra frames", start_cyc.size(), 10);
        chk("t2 seq_out", {24'h0, seq_out}, 32'h02);

        // table of frames; payload is scrambled mid-frame to prove the snapshot holds
        apply_reset("t3 reset");
        reset = 1'b0;
        foreach (vecs[i]) begin
            @(negedge clk);
            enable = 1'b1; payload_in = vecs[i].payload;
            pulse_send();
            repeat (27) @(negedge clk);
            payload_in = ~vecs[i].payload;
            wait_end(i + 1, 200, $sformatf("t3 vec%0d", i));
            chk_frame($sformatf("t3 vec%0d", i), 5 * i, vecs[i].frame);
            chk($sformatf("t3 vec%0d seq_out", i), {24'h0, seq_out}, {24'h0, vecs[i].seq_after});
            enable = 1'b0;
        end

        // timeout on the SEQ byte, then a clean restart
        apply_reset("t4 reset");
        reset = 1'b0; enable = 1'b1; payload_in = 16'h3412; drop_at = 1;
        pulse_send();
        wait_end(1, 200, "t4 abort");
        chk("t4 tx_error count", n_err, 1);
        chk("t4 frame_done count", n_done, 0);
        chk("t4 bytes sent", start_cyc.size(), 2);
        chk("t4 error cycle", err_cyc, (start_cyc.size() > 1 ? start_cyc[1] : 0) + 50);
        chk("t4 seq_out", {24'h0, seq_out}, 32'h00);
        @(negedge clk);
        chk("t4 busy", {31'h0, busy}, 32'h0);
        enable = 1'b0;
        @(negedge clk);
        drop_at = -1; enable = 1'b1;
        pulse_send();
        wait_end(2, 200, "t4 retry");
        chk_frame("t4 retry", 2, 40'hA5_00_12_34_26);
        chk("t4 retry seq_out", {24'h0, seq_out}, 32'h01);
        enable = 1'b0;

        // asynchronous reset in the middle of a payload byte
        apply_reset("t5 reset");
        reset = 1'b0; enable = 1'b1; payload_in = 16'h3412;
        pulse_send();
        wait_end(1, 200, "t5 frame0");
        chk("t5 seq before", {24'h0, seq_out}, 32'h01);
        pulse_send();
        repeat (27) @(negedge clk);
        chk("t5 tx_data before reset", {24'h0, tx_data}, 32'h12);
        reset = 1'b1;
        #1;
        chk_reset_outputs("t5 async");
        repeat (2) @(negedge clk);
        reset = 1'b0;
        nb = start_cyc.size();
        repeat (40) @(negedge clk);
        chk("t5 no start after release", start_cyc.size(), nb);
        chk("t5 stray tick ignored", n_done + n_err, 1);
        pulse_send();
        wait_end(2, 200, "t5 restart");
        chk_frame("t5 restart", nb, 40'hA5_00_12_34_26);
        enable = 1'b0;

        // enable dropped mid-frame with a trigger pending
        apply_reset("t6 reset");
        reset = 1'b0; enable = 1'b1; payload_in = 16'h3412;
        pulse_send();
        repeat (20) @(negedge clk);
        pulse_send();
        repeat (5) @(negedge clk);
        enable = 1'b0;
        wait_end(1, 200, "t6 frame0");
        chk_frame("t6 frame0", 0, 40'hA5_00_12_34_26);
        repeat (200) @(negedge clk);
        chk("t6 no further frames", start_cyc.size(), 5);
        chk("t6 frame_done count", n_done, 1);
        enable = 1'b1; c0 = cyc;
        wait_end(2, 300, "t6 periodic");
        chk("t6 timer held at zero", start_cyc.size() > 5 ? start_cyc[5] : -1, c0 + 101);
        chk_frame("t6 periodic", 5, 40'hA5_01_12_34_27);
        enable = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
